// File: rtl/addseq_pkg.sv
// Shared types and constants for the wide add/subtract sequencer.
// Holds the FSM state enum, default sizes and the word-index width helper.
package addseq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_WORDS = 4;

    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/full_adder_32_bits.sv
// Word-wide ripple adder used as the shared datapath.
// Ports: a, b (operands), cin (carry in), sum (result), cout (carry out).
module full_adder_32_bits #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH*WORDS add/subtract over one shared WIDTH-bit adder,
// one word per cycle LSW first, carry chained through a register.
// Ports: clk, rst_n (async, active-low), start/a_in/b_in/cin/sub (command),
// busy/done/result/cout/overflow (registered status and result).
// Macro ADDSEQ_SUB_EN: when defined, sub selects A-B-cin; otherwise add-only.
module wide_add_sequencer
    import addseq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] a_in,
    input  logic [WIDTH*WORDS-1:0] b_in,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] result,
    output logic                   cout,
    output logic                   overflow
);

    localparam int IW = idx_w(WORDS);
    typedef logic [IW-1:0] idx_t;
    localparam idx_t LAST = idx_t'(WORDS - 1);

    state_t                       state_q;
    idx_t                         idx_q;
    logic [WORDS-1:0][WIDTH-1:0]  a_q;
    logic [WORDS-1:0][WIDTH-1:0]  b_q;
    logic [WORDS-1:0][WIDTH-1:0]  res_q;
    logic                         cin_q;
    logic                         carry_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         cout_q;
    logic                         ovf_q;

    logic [WIDTH-1:0] a_w;
    logic [WIDTH-1:0] b_w;
    logic [WIDTH-1:0] sum_w;
    logic             ci_w;
    logic             co_w;

    assign a_w = a_q[idx_q];

`ifdef ADDSEQ_SUB_EN
    logic sub_q;
    // Subtract is A + ~B + 1, with the borrow-in folded into the first carry.
    assign b_w  = b_q[idx_q] ^ {WIDTH{sub_q}};
    assign ci_w = (idx_q == '0) ? (cin_q ^ sub_q) : carry_q;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_w  = b_q[idx_q];
    assign ci_w = (idx_q == '0) ? cin_q : carry_q;
`endif

    full_adder_32_bits #(
        .WIDTH(WIDTH)
    ) u_add (
        .a   (a_w),
        .b   (b_w),
        .cin (ci_w),
        .sum (sum_w),
        .cout(co_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ADDSEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        cin_q   <= cin;
`ifdef ADDSEQ_SUB_EN
                        sub_q   <= sub;
`endif
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[idx_q] <= sum_w;
                    carry_q      <= co_w;
                    if (idx_q == LAST) begin
                        cout_q  <= co_w;
                        // Signed overflow: same-sign operands, sign flips.
                        ovf_q   <= (a_w[WIDTH-1] == b_w[WIDTH-1]) &&
                                   (sum_w[WIDTH-1] != a_w[WIDTH-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = res_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer (WIDTH=32, WORDS=4).
// Expected values are hand-computed; ADDSEQ_SUB_EN selects subtract vectors.
module tb_wide_add_sequencer;

    localparam int W = 32;
    localparam int N = 4;
    localparam int TW = W * N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [TW-1:0] a_in;
    logic [TW-1:0] b_in;
    logic          cin;
    logic          sub;
    logic          busy;
    logic          done;
    logic [TW-1:0] result;
    logic          cout;
    logic          overflow;

    int checks;
    int failures;

    logic [4:0] busy_seq;
    logic [4:0] done_seq;
    logic       seen_done;

    wide_add_sequencer #(
        .WIDTH(W),
        .WORDS(N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .sub     (sub),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TW-1:0] got,
                       input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one op at a negedge, then samples busy/done on the
    // negedges of T+1..T+5; returns at the T+5 negedge.
    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic c, input logic s);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seq = '0;
        done_seq = '0;
        for (int k = 0; k < 5; k++) begin
            busy_seq[k] = busy;
            done_seq[k] = done;
            if (k < 4) @(negedge clk);
        end
    endtask

    task automatic chk_out(input string tag, input logic [TW-1:0] r,
                           input logic co, input logic ov);
        chk({tag, "_busy"}, TW'(busy_seq), TW'(5'b01111));
        chk({tag, "_done"}, TW'(done_seq), TW'(5'b10000));
        chk({tag, "_res"}, result, r);
        chk({tag, "_cout"}, TW'(cout), TW'(co));
        chk({tag, "_ovf"}, TW'(overflow), TW'(ov));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_flags", TW'({busy, done, cout, overflow}), '0);
        chk("rst_res", result, '0);
        rst_n = 1'b1;

        run_op({TW{1'b1}}, TW'(1), 1'b0, 1'b0);
        chk_out("ripple", '0, 1'b1, 1'b0);

        run_op(TW'(1), TW'(2), 1'b1, 1'b0);
        chk_out("add", TW'(4), 1'b0, 1'b0);

        run_op(TW'(5), TW'(7), 1'b0, 1'b1);
`ifdef ADDSEQ_SUB_EN
        chk_out("sub", {{(TW-4){1'b1}}, 4'hE}, 1'b0, 1'b0);
`else
        chk_out("sub", TW'(12), 1'b0, 1'b0);
`endif

        run_op({1'b0, {(TW-1){1'b1}}}, TW'(1), 1'b0, 1'b0);
        chk_out("ovf", {1'b1, {(TW-1){1'b0}}}, 1'b0, 1'b1);

        // Start held during RUN/DONE must be ignored until IDLE.
        @(negedge clk);
        a_in  = TW'(100);
        b_in  = TW'(23);
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in  = 128'h00000000_FFFFFFFF_FFFFFFFF_00000005;
        b_in  = 128'h00000000_00000000_00000001_00000003;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_done1", TW'(done), TW'(1));
        chk("hold_res1", result, TW'(123));
        @(negedge clk);
        chk("hold_idle", TW'({busy, done}), '0);
        @(negedge clk);
        start = 1'b0;
        chk("hold_busy2", TW'(busy), TW'(1));
        repeat (4) @(negedge clk);
        chk("hold_done2", TW'(done), TW'(1));
        chk("hold_res2", result, 128'h00000001_00000000_00000000_00000008);

        // Reset in the middle of an operation.
        @(negedge clk);
        a_in  = TW'(9);
        b_in  = TW'(9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", TW'({busy, done, cout, overflow}), '0);
        chk("mid_rst_res", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        chk("mid_rst_nodone", TW'(seen_done), '0);

        run_op(TW'(3), TW'(4), 1'b0, 1'b0);
        chk_out("after_rst", TW'(7), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
